stim_gen: RTL
=============

STIM_GEN -- requirements
Module: stim_gen

Interface
REQ-001 Parameter N_CH, default 4: number of stimulus channels (2..16).
REQ-002 Parameter DIV_W, default 8: prescaler width in bits.
REQ-003 Ports SHALL be declared in this order:
- clk  in  1  the single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; single-cycle pulse.
- stop  in  1  abort a run; single-cycle pulse.
- one_shot  in  1  1 = end after one full sequence; 0 = wrap forever.
- mode  in  2  0 = binary, 1 = Gray, 2 = walking-one, 3 = reserved (treated as 0).
- div  in  DIV_W  a step occurs every div+1 clocks.
- ch  out  N_CH  stimulus vector.
- parity  out  1  XOR of all ch bits, registered with ch.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a one-shot run completes.
- step  out  N_CH  current sequence index.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN on start.
- RUN -> IDLE on stop.
- RUN -> DONE on the final step when one_shot = 1.
- DONE -> IDLE after exactly one cycle.
REQ-005 On start in IDLE, the block SHALL latch mode, div and one_shot, clear step and clear the prescaler; the latched values are held until the next start.
REQ-006 The prescaler SHALL count 0..div in RUN and assert an internal tick when count = div; div = 0 gives a tick every clock.
REQ-007 On each tick, step SHALL increment modulo 2^N_CH.
REQ-008 ch SHALL be registered from the new step value:
- binary: ch = step.
- Gray: ch = step ^ (step >> 1).
- walking-one: ch = 1 << (step mod N_CH).
REQ-009 In binary mode, bit i SHALL therefore toggle every 2^i ticks (bit 0 fastest).
REQ-010 Walking-one SHALL wrap after N_CH steps; one_shot completion in this mode occurs at step = N_CH-1.
REQ-011 In one_shot, the final step is step = 2^N_CH-1 (binary/Gray); on the tick after it, the FSM SHALL enter DONE and ch SHALL hold its last value.
REQ-012 With one_shot = 0, step SHALL wrap from 2^N_CH-1 to 0 with no gap tick.
REQ-013 parity SHALL equal ^ch in the same cycle that ch updates.
REQ-014 done SHALL be high only in DONE; busy SHALL be high only in RUN.
REQ-015 Simultaneous start and stop:
- in IDLE, stop SHALL win (stay IDLE);
- in RUN, stop SHALL win (go IDLE); start is ignored.
REQ-016 start during RUN or DONE SHALL be ignored.
REQ-017 On stop, ch and step SHALL hold their values; they are cleared only by the next start or by rst.
REQ-018 Changes to the mode/div/one_shot inputs during RUN SHALL have no effect.

Reset
REQ-019 When rst is high at a clk edge, the block SHALL enter IDLE and clear ch, step, parity, busy, done, the prescaler and the latched config.
REQ-020 rst SHALL take priority over start and stop in the same cycle.
REQ-021 rst mid-run SHALL abort with no done pulse.
REQ-022 The first start after rst deasserts SHALL be honoured in the same cycle.

Structure
REQ-023 A shared package stim_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the mode encodings MODE_BIN = 0, MODE_GRAY = 1, MODE_WALK = 2.
REQ-024 The prescaler SHALL be a sub-module, stim_tick, with ports clk, rst, clr, en, div and tick.
REQ-025 The pattern mapping SHALL be combinational logic on step, placed in front of the ch register.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- N_CH = 4, div = 0, mode = 0, one_shot = 1, start -> ch steps 0..15 on consecutive clocks; done pulses once, 16 clocks after ch = 1; busy falls in the same cycle.
- div = 3, mode = 0 -> ch changes every 4 clocks; ch[0] half-period 4 clocks, ch[3] half-period 32 clocks.
- mode = 1, one_shot = 1 -> ch Hamming distance between successive values is always 1; final ch = 4'b1000.
- mode = 2, one_shot = 0, div = 0 -> ch sequence 0001, 0010, 0100, 1000, 0001 …; parity = 1 on every step after the first.
- stop at step 5, then start -> ch holds 5 while IDLE; after start it restarts at 0; start and stop in the same cycle leaves the block IDLE.
- rst asserted at step 9 of a one-shot run -> all outputs 0 on the next clock and no done pulse.

Source files
------------

// File: rtl/stim_pkg.sv
// Shared types for the stimulus generator: FSM state encoding and pattern-mode codes.
// Pure declarations, no logic; the top and the prescaler import this.
package stim_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] MODE_BIN  = 2'd0;
   localparam logic [1:0] MODE_GRAY = 2'd1;
   localparam logic [1:0] MODE_WALK = 2'd2;

endpackage

// File: rtl/stim_tick.sv
// Step prescaler: counts 0..div while enabled and flags tick combinationally on the last count.
// No backpressure; clr restarts the count so the first tick lands div+1 clocks after enable.
module stim_tick #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] count_q;

   assign tick = en && (count_q == div);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= tick ? '0 : count_q + DIV_W'(1);
      end
   end

endmodule

// File: rtl/stim_gen.sv
// Stimulus generator: binary / Gray / walking-one patterns stepped every div+1 clocks.
// ch and parity are registered from the next step value, so they update on the same edge as step.
module stim_gen
   import stim_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             one_shot,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div,
   output logic [N_CH-1:0]  ch,
   output logic             parity,
   output logic             busy,
   output logic             done,
   output logic [N_CH-1:0]  step
);

   localparam logic [N_CH-1:0] WALK_LAST = N_CH'(N_CH - 1);

   state_t            state_q, state_d;
   logic [1:0]        mode_q;
   logic [DIV_W-1:0]  div_q;
   logic              one_shot_q;
   logic [N_CH-1:0]   step_q, step_d;
   logic [N_CH-1:0]   ch_q;
   logic              parity_q;

   logic              load;
   logic              adv;
   logic              tick;
   logic [1:0]        mode_eff;
   logic [N_CH-1:0]   last_step;
   logic [N_CH-1:0]   pat;
   int unsigned       walk_idx;

   stim_tick #(
      .DIV_W (DIV_W)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (load),
      .en   (state_q == RUN),
      .div  (div_q),
      .tick (tick)
   );

   // Walking-one completes a one-shot run after N_CH steps, the counting modes after 2^N_CH.
   assign last_step = (mode_q == MODE_WALK) ? WALK_LAST : '1;

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      adv      = 1'b0;
      step_d   = step_q;
      mode_eff = mode_q;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (tick) begin
               if (one_shot_q && (step_q == last_step)) begin
                  state_d = DONE;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // On a start the fresh mode input selects the first pattern, before it is latched.
      if (load) begin
         step_d   = '0;
         mode_eff = mode;
      end else if (adv) begin
         step_d = step_q + N_CH'(1);
      end
   end

   always_comb begin
      pat      = step_d;
      walk_idx = 32'(step_d) % N_CH;
      case (mode_eff)
         MODE_BIN:  pat = step_d;
         MODE_GRAY: pat = step_d ^ (step_d >> 1);
         MODE_WALK: begin
            for (int i = 0; i < N_CH; i++) begin
               pat[i] = (walk_idx == $unsigned(i));
            end
         end
         default:   pat = step_d;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mode_q     <= '0;
         div_q      <= '0;
         one_shot_q <= 1'b0;
         step_q     <= '0;
         ch_q       <= '0;
         parity_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         if (load) begin
            mode_q     <= mode;
            div_q      <= div;
            one_shot_q <= one_shot;
         end
         if (load || adv) begin
            ch_q     <= pat;
            parity_q <= ^pat;
         end
      end
   end

   assign ch     = ch_q;
   assign parity = parity_q;
   assign step   = step_q;
   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);

endmodule
